pipeline_hazard_controller: RTL and testbench



---
 rtl/pipeline_ctrl_pkg.sv | 25 ++
 rtl/hazard_mem_wait_fsm.sv | 78 +++++++
 rtl/pipeline_hazard_controller.sv | 111 +++++++++++
 tb/tb_pipeline_hazard_controller.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The memory-wait FSM encoding lives here so the top and the bench agree on it.
package pipeline_ctrl_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

   // Wide enough for the largest legal MEM_TIMEOUT (255).
   localparam int unsigned WAIT_CNT_W = 8;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } hz_state_e;

   // True when a non-$zero destination feeds the given source field.
   function automatic logic reg_dep(
      input logic [REG_ADDR_W-1:0] dst,
      input logic [REG_ADDR_W-1:0] src
   );
      return (dst != ZERO_REG) && (dst == src);
   endfunction

endpackage

// File: rtl/hazard_mem_wait_fsm.sv
// Memory-wait sequencer: freezes the pipeline while a data-RAM access is
// outstanding and latches a sticky error when the access exceeds MEM_TIMEOUT.
module hazard_mem_wait_fsm
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic mem_req,
   input  logic mem_ready,
   output logic freeze,
   output logic mem_timeout_err
);

   localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

   hz_state_e              state_q, state_d;
   logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic                   err_q, err_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      // Flag follows one cycle behind the ERROR state and then sticks.
      err_d      = err_q | (state_q == ERROR);
      case (state_q)
         RUN: begin
            if (mem_req && !mem_ready) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = WAIT_CNT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (mem_ready) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == TIMEOUT_LAST) begin
               state_d = ERROR;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         ERROR: begin
            state_d = ERROR;
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      freeze = 1'b0;
      case (state_q)
         RUN:      freeze = mem_req & ~mem_ready;
         MEM_WAIT: freeze = ~mem_ready;
         ERROR:    freeze = 1'b1;
         default:  freeze = 1'b1;
      endcase
   end

   assign mem_timeout_err = err_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline register sequencer: load-use stall, branch/jump flush and memory freeze.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_controller
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rt,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_write_register,
   input  logic                  branch_taken,
   input  logic                  jump,
   input  logic                  mem_req,
   input  logic                  mem_ready,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  if_id_flush,
   output logic                  id_ex_write,
   output logic                  id_ex_flush,
   output logic                  ex_mem_write,
   output logic                  mem_wb_bubble,
   output logic                  mem_timeout_err,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_count
);

   logic freeze;
   logic load_use;
   logic flush;

   hazard_mem_wait_fsm #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_fsm (
      .clk             (clk),
      .reset           (reset),
      .mem_req         (mem_req),
      .mem_ready       (mem_ready),
      .freeze          (freeze),
      .mem_timeout_err (mem_timeout_err)
   );

   always_comb begin
      load_use = ex_mem_read &
                 (reg_dep(ex_write_register, id_rs) |
                  (id_uses_rt & reg_dep(ex_write_register, id_rt)));
      flush    = branch_taken | jump;
   end

   // Priority: freeze, then flush (discards the hazarding instruction), then load-use.
   always_comb begin
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_write   = 1'b1;
      id_ex_flush   = 1'b0;
      ex_mem_write  = 1'b1;
      mem_wb_bubble = 1'b0;
      if (freeze) begin
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         id_ex_write   = 1'b0;
         ex_mem_write  = 1'b0;
         mem_wb_bubble = 1'b1;
      end else if (flush) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (load_use) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] flush_count_q, flush_count_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (!pc_write && (stall_cycles_q != '1)) begin
         stall_cycles_d = stall_cycles_q + 1'b1;
      end
      if (flush && !freeze && (flush_count_q != '1)) begin
         flush_count_d = flush_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed self-checking bench for pipeline_hazard_controller (MEM_TIMEOUT=4).
// Counter expectations switch to zero when HAZARD_PERF_CNT_EN is undefined.
module tb_pipeline_hazard_controller;
   import pipeline_ctrl_pkg::*;

   localparam int unsigned CNT_W = 16;
`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_bubble}
   localparam logic [6:0] O_IDLE   = 7'b1101010;
   localparam logic [6:0] O_FREEZE = 7'b0000001;
   localparam logic [6:0] O_FLUSH  = 7'b1111110;
   localparam logic [6:0] O_LDUSE  = 7'b0001110;

   logic             clk = 1'b0;
   logic             reset;
   logic [4:0]       id_rs, id_rt, ex_write_register;
   logic             id_uses_rt, ex_mem_read, branch_taken, jump, mem_req, mem_ready;
   logic             pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
   logic             ex_mem_write, mem_wb_bubble, mem_timeout_err;
   logic [CNT_W-1:0] stall_cycles, flush_count;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   always #5 clk = ~clk;

   pipeline_hazard_controller #(
      .MEM_TIMEOUT (4),
      .CNT_W       (CNT_W)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .id_rs             (id_rs),
      .id_rt             (id_rt),
      .id_uses_rt        (id_uses_rt),
      .ex_mem_read       (ex_mem_read),
      .ex_write_register (ex_write_register),
      .branch_taken      (branch_taken),
      .jump              (jump),
      .mem_req           (mem_req),
      .mem_ready         (mem_ready),
      .pc_write          (pc_write),
      .if_id_write       (if_id_write),
      .if_id_flush       (if_id_flush),
      .id_ex_write       (id_ex_write),
      .id_ex_flush       (id_ex_flush),
      .ex_mem_write      (ex_mem_write),
      .mem_wb_bubble     (mem_wb_bubble),
      .mem_timeout_err   (mem_timeout_err),
      .stall_cycles      (stall_cycles),
      .flush_count       (flush_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [6:0] exp);
      check(tag, {25'd0, pc_write, if_id_write, if_id_flush, id_ex_write,
                  id_ex_flush, ex_mem_write, mem_wb_bubble}, {25'd0, exp});
   endtask

   task automatic idle_inputs();
      id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
      ex_mem_read = 1'b0; ex_write_register = 5'd0;
      branch_taken = 1'b0; jump = 1'b0;
      mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   // Drive new inputs just after the falling edge; outputs are sampled 1ns later.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      step(); idle_inputs(); reset = 1'b1;
      step(); reset = 1'b0;
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      step();
      do_reset();
      #1;
      check_outs("reset_outs", O_IDLE);
      check("reset_err", {31'd0, mem_timeout_err}, 32'd0);
      check("reset_stall", {16'd0, stall_cycles}, 32'd0);
      check("reset_flush", {16'd0, flush_count}, 32'd0);

      // Load-use through rs, then clears once the load moves on
      step(); ex_mem_read = 1'b1; ex_write_register = 5'd8; id_rs = 5'd8; #1;
      check_outs("lduse_rs", O_LDUSE);
      step(); ex_mem_read = 1'b0; #1;
      check_outs("lduse_rs_next", O_IDLE);

      // Load-use through rt
      step(); ex_mem_read = 1'b1; ex_write_register = 5'd9; id_rs = 5'd3;
      id_rt = 5'd9; id_uses_rt = 1'b1; #1;
      check_outs("lduse_rt", O_LDUSE);
      step(); id_uses_rt = 1'b0; ex_write_register = 5'd8; id_rt = 5'd8; #1;
      check_outs("rt_unused", O_IDLE);
      step(); ex_write_register = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1; #1;
      check_outs("zero_reg", O_IDLE);
      check("stall_after_lduse", {16'd0, stall_cycles}, PERF ? 32'd2 : 32'd0);

      // Branch with simultaneous load-use: flush wins
      step(); ex_write_register = 5'd8; id_rs = 5'd8; branch_taken = 1'b1; #1;
      check_outs("branch_hazard", O_FLUSH);
      step(); idle_inputs(); #1;
      check_outs("branch_next", O_IDLE);
      check("flush_cnt_1", {16'd0, flush_count}, PERF ? 32'd1 : 32'd0);
      step(); jump = 1'b1; #1;
      check_outs("jump", O_FLUSH);
      step(); idle_inputs(); #1;
      check("flush_cnt_2", {16'd0, flush_count}, PERF ? 32'd2 : 32'd0);
      check("stall_unchanged", {16'd0, stall_cycles}, PERF ? 32'd2 : 32'd0);

      // Memory wait: three frozen cycles, completion on the fourth
      do_reset();
      mem_req = 1'b1; mem_ready = 1'b0; #1;
      check_outs("mw_c1", O_FREEZE);
      step(); branch_taken = 1'b1; #1;
      check_outs("mw_c2_flush_suppressed", O_FREEZE);
      step(); branch_taken = 1'b0; ex_mem_read = 1'b1; ex_write_register = 5'd4; id_rs = 5'd4; #1;
      check_outs("mw_c3_lduse_suppressed", O_FREEZE);
      step(); idle_inputs(); mem_req = 1'b1; mem_ready = 1'b1; #1;
      check_outs("mw_c4_complete", O_IDLE);
      step(); mem_req = 1'b0; mem_ready = 1'b1; #1;
      check_outs("ready_no_req", O_IDLE);
      check("mw_state_run", {30'd0, dut.u_fsm.state_q}, {30'd0, RUN});
      check("mw_stall", {16'd0, stall_cycles}, PERF ? 32'd3 : 32'd0);
      check("mw_flush", {16'd0, flush_count}, 32'd0);

      // Timeout into ERROR, then recovery by reset
      do_reset();
      mem_req = 1'b1; mem_ready = 1'b0; #1;
      check_outs("to_c1", O_FREEZE);
      step(); #1;
      step(); #1;
      step(); #1;
      check_outs("to_c4", O_FREEZE);
      check("to_c4_state", {30'd0, dut.u_fsm.state_q}, {30'd0, MEM_WAIT});
      step(); mem_req = 1'b0; mem_ready = 1'b1; #1;
      check("to_c5_state", {30'd0, dut.u_fsm.state_q}, {30'd0, ERROR});
      check_outs("to_c5_frozen", O_FREEZE);
      step(); #1;
      check("to_err", {31'd0, mem_timeout_err}, 32'd1);
      check_outs("to_c6_frozen", O_FREEZE);
      check("to_stall", {16'd0, stall_cycles}, PERF ? 32'd5 : 32'd0);
      step(); reset = 1'b1;
      step(); reset = 1'b0; idle_inputs(); #1;
      check_outs("to_recover", O_IDLE);
      check("to_err_cleared", {31'd0, mem_timeout_err}, 32'd0);

      // Reset in the middle of a wait
      step(); mem_req = 1'b1; mem_ready = 1'b0; #1;
      step(); #1;
      step(); #1;
      check("mid_cnt2", {24'd0, dut.u_fsm.wait_cnt_q}, 32'd2);
      reset = 1'b1;
      step(); reset = 1'b0; idle_inputs(); #1;
      check_outs("mid_outs", O_IDLE);
      check("mid_state", {30'd0, dut.u_fsm.state_q}, {30'd0, RUN});
      check("mid_cnt0", {24'd0, dut.u_fsm.wait_cnt_q}, 32'd0);
      check("mid_stall", {16'd0, stall_cycles}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
